capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//   Capture sequencer between the trigger logic (chan_trig / prot_trig) and the five channel RAMs.
//   Runs a circular sample buffer and fills the pre-trigger region before arming.
//   Then waits for the combined trigger and records trig_pos post-trigger samples.
//   On completion it reports done and the oldest-sample address to cmd_cfg for readout.
// PARAMETERS
//   ENTRIES  384  depth of each channel RAM in samples (12288 on DE-0)
//   LOG2     9    address width, ceil(log2(ENTRIES))
// PORTS
//   clk               in   1     100MHz system clock
//   rst_n             in   1     asynchronous active-low reset
//   run               in   1     capture enable level from cmd_cfg; 0 aborts and returns to IDLE
//   wrt_smpl          in   1     sample strobe; one RAM write per high cycle while capturing
//   trig              in   1     combined trigger, already registered upstream
//   trig_pos          in   LOG2  number of post-trigger samples to record
//   we                out  1     write enable to all channel RAMs
//   waddr             out  LOG2  write address to all channel RAMs
//   set_armed         out  1     1-cycle pulse when the pre-trigger fill completes
//   armed             out  1     level, high while in ARMED or POST
//   set_capture_done  out  1     1-cycle pulse on entry to DONE
//   capture_done      out  1     level, high while in DONE
//   addr_ptr          out  LOG2  address of the oldest sample, latched on DONE entry
// BEHAVIOUR
//   Reset: state=IDLE, waddr=0, addr_ptr=0, all other outputs 0, internal counters 0.
//   States: IDLE -> FILL -> ARMED -> POST -> DONE -> IDLE.
//   we = wrt_smpl & (state==FILL | state==ARMED | (state==POST & post_cnt<tp_q)). we is combinational.
//     The write uses the current waddr.
//     waddr advances on the following clock and wraps ENTRIES-1 -> 0.
//   IDLE: on run=1, go to FILL next cycle.
//     At the same time: waddr<=0, pre_cnt<=0, post_cnt<=0, tp_q<=min(trig_pos, ENTRIES-1).
//     tp_q is latched at this point; later changes to trig_pos are ignored until the next run.
//   FILL: each write increments pre_cnt.
//     On the write that makes pre_cnt == ENTRIES-tp_q, go to ARMED and pulse set_armed.
//     trig is ignored in FILL.
//   ARMED: writes continue around the circular buffer.
//     trig=1 moves the FSM to POST and clears post_cnt.
//     A sample written in the same cycle as trig counts as pre-trigger.
//   POST: each write increments post_cnt.
//     In the cycle where post_cnt == tp_q: no write; go to DONE; pulse set_capture_done; addr_ptr<=waddr.
//     With tp_q=0, POST lasts exactly 1 cycle and writes nothing.
//   DONE: we=0, capture_done=1, waddr held. Stays in DONE until run=0, then goes to IDLE.
//   run=0 in FILL, ARMED or POST: go to IDLE next cycle.
//     we is gated low in that same cycle.
//     No set_capture_done pulse; addr_ptr keeps its previous value.
//   wrt_smpl high on every cycle is legal; the FSM takes at most one write per cycle.
//   pre_cnt and post_cnt are LOG2+1 bits wide, so the compares cannot overflow.
//   rst_n assertion at any point returns the block to the reset values asynchronously.
// TESTING
//   1. trig_pos=100, run=1, wrt_smpl every 4th clk.
//      -> set_armed pulses on the 284th write.
//      -> trig in ARMED, then exactly 100 more writes.
//      -> set_capture_done pulses for 1 cycle; addr_ptr == waddr; buffer wraps 383->0.
//   2. trig_pos=0, trig asserted 50 writes after armed.
//      -> POST lasts 1 cycle with we=0.
//      -> addr_ptr == waddr following the last pre-trigger write.
//   3. trig pulsed during FILL, then again 10 writes after armed.
//      -> first trig ignored.
//      -> POST entered only on the second trig.
//   4. trig_pos=450.
//      -> clamped to 383.
//      -> set_armed after the 1st write; done after 383 post-trigger writes.
//   5. run dropped mid-POST.
//      -> IDLE next cycle; we=0; no done pulse.
//      -> run re-asserted: waddr restarts at 0; trig_pos re-latched.
//   6. rst_n low mid-ARMED with wrt_smpl held high.
//      -> we, armed and waddr are 0 immediately (before the next clk edge).
//      -> FSM stays in IDLE after release until run is seen high.

Source files
------------

// File: rtl/capture_ctrl.sv
// ---------------------------------------------------------------------------
// capture_ctrl
//   Capture sequencer sitting between the trigger logic and the channel RAMs.
//   A circular sample buffer is filled with pre-trigger samples until only
//   trig_pos slots remain. The block then arms and waits for the combined
//   trigger, records trig_pos post-trigger samples and reports completion
//   together with the address of the oldest sample in the buffer.
//
// Ports
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   run               in   capture enable level; low aborts back to IDLE
//   wrt_smpl          in   sample strobe, at most one RAM write per cycle
//   trig              in   combined trigger (registered upstream)
//   trig_pos[LOG2]    in   number of post-trigger samples to record
//   we                out  write enable to all channel RAMs (combinational)
//   waddr[LOG2]       out  write address to all channel RAMs
//   set_armed         out  1-cycle pulse on the write that completes the fill
//   armed             out  high while ARMED or POST
//   set_capture_done  out  1-cycle pulse in the cycle that enters DONE
//   capture_done      out  high while DONE
//   addr_ptr[LOG2]    out  oldest-sample address, latched on DONE entry
// ---------------------------------------------------------------------------
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            wrt_smpl,
  input  logic            trig,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            set_armed,
  output logic            armed,
  output logic            set_capture_done,
  output logic            capture_done,
  output logic [LOG2-1:0] addr_ptr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] ARMED = 3'd2;
  localparam logic [2:0] POST  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE_ADDR  = LOG2'(1);
  localparam logic [LOG2:0]   DEPTH     = (LOG2 + 1)'(ENTRIES);
  localparam logic [LOG2:0]   ONE_CNT   = (LOG2 + 1)'(1);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [LOG2:0]   pre_cnt;
  logic [LOG2:0]   post_cnt;
  logic [LOG2:0]   pre_inc;
  logic [LOG2:0]   tp_ext;
  logic [LOG2:0]   fill_target;
  logic [LOG2-1:0] tp_q;
  logic [LOG2-1:0] tp_clamped;
  logic [LOG2-1:0] waddr_inc;

  // The counters carry one extra bit so that a full-depth fill (tp_q = 0)
  // can be compared against ENTRIES without wrapping.
  assign tp_ext      = {1'b0, tp_q};
  assign pre_inc     = pre_cnt + ONE_CNT;
  assign fill_target = DEPTH - tp_ext;

  // At most ENTRIES-1 post-trigger samples, so at least one pre-trigger
  // sample is always kept in the buffer.
  assign tp_clamped = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;

  assign waddr_inc = (waddr == LAST_ADDR) ? '0 : waddr + ONE_ADDR;

  assign armed        = (state == ARMED) || (state == POST);
  assign capture_done = (state == DONE);

  // Next state and Mealy outputs. Dropping run gates the write and the
  // done pulse in the same cycle, so an abort never looks like a capture.
  always_comb begin
    state_nxt        = state;
    we               = 1'b0;
    set_armed        = 1'b0;
    set_capture_done = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FILL;
      end
      FILL: begin
        if (!run) begin
          state_nxt = IDLE;
        end else begin
          we = wrt_smpl;
          if (wrt_smpl && (pre_inc == fill_target)) begin
            state_nxt = ARMED;
            set_armed = 1'b1;
          end
        end
      end
      ARMED: begin
        if (!run) begin
          state_nxt = IDLE;
        end else begin
          we = wrt_smpl;
          if (trig) state_nxt = POST;
        end
      end
      POST: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (post_cnt == tp_ext) begin
          state_nxt        = DONE;
          set_capture_done = 1'b1;
        end else begin
          we = wrt_smpl;
        end
      end
      DONE: begin
        if (!run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // trig_pos is sampled once per run; later changes wait for the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr    <= '0;
      pre_cnt  <= '0;
      tp_q     <= '0;
    end else if ((state == IDLE) && run) begin
      waddr    <= '0;
      pre_cnt  <= '0;
      tp_q     <= tp_clamped;
    end else begin
      if (we) waddr <= waddr_inc;
      if ((state == FILL) && we) pre_cnt <= pre_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_cnt <= '0;
    end else if ((state == IDLE) && run) begin
      post_cnt <= '0;
    end else if ((state == ARMED) && run && trig) begin
      post_cnt <= '0;
    end else if ((state == POST) && we) begin
      post_cnt <= post_cnt + ONE_CNT;
    end
  end

  // Once the buffer has been filled, the next address to be written is the
  // oldest sample, which is where readout has to start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr <= '0;
    end else if (set_capture_done) begin
      addr_ptr <= waddr;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_ctrl
//   Directed testbench for capture_ctrl with hand-computed expectations:
//   sparse-strobe capture with buffer wrap, zero post-trigger length,
//   trigger during fill, trig_pos clamping, abort mid-POST with re-run,
//   and asynchronous reset while armed.
// ---------------------------------------------------------------------------
module tb_capture_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int BUDGET  = 3000;

  logic            clk;
  logic            rst_n;
  logic            run;
  logic            wrt_smpl;
  logic            trig;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            set_armed;
  logic            armed;
  logic            set_capture_done;
  logic            capture_done;
  logic [LOG2-1:0] addr_ptr;

  int checks;
  int errors;

  logic obs_we;
  logic obs_sa;
  logic obs_scd;

  int arm_at;
  int post_wr;
  int done_seen;

  capture_ctrl #(
    .ENTRIES(ENTRIES),
    .LOG2   (LOG2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .wrt_smpl        (wrt_smpl),
    .trig            (trig),
    .trig_pos        (trig_pos),
    .we              (we),
    .waddr           (waddr),
    .set_armed       (set_armed),
    .armed           (armed),
    .set_capture_done(set_capture_done),
    .capture_done    (capture_done),
    .addr_ptr        (addr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", tag, actual, expected);
    end
  endtask

  // Called 1 time unit after a rising edge: drive inputs, sample the
  // combinational outputs mid-cycle, then advance past the next edge.
  task automatic applyStimulus(input logic ws, input logic tg);
    wrt_smpl = ws;
    trig     = tg;
    #2;
    obs_we  = we;
    obs_sa  = set_armed;
    obs_scd = set_capture_done;
    @(posedge clk);
    #1;
  endtask

  // Strobe every period-th cycle until set_armed; returns the write count
  // at which it pulsed, or -1 if the budget expires.
  task automatic fillUntilArmed(input int period, input int trig_at, output int arm_write);
    int wr;
    wr        = 0;
    arm_write = -1;
    for (int i = 0; i < BUDGET; i++) begin
      applyStimulus((i % period) == (period - 1), i == trig_at);
      if (obs_we) wr++;
      if (obs_sa) begin
        arm_write = wr;
        break;
      end
    end
  endtask

  // Strobe every period-th cycle until set_capture_done; counts the
  // post-trigger writes seen before it.
  task automatic postUntilDone(input int period, output int writes, output int seen);
    writes = 0;
    seen   = 0;
    for (int i = 0; i < BUDGET; i++) begin
      applyStimulus((i % period) == (period - 1), 1'b0);
      if (obs_scd) begin
        seen = 1;
        if (obs_we) writes = writes + 1000;
        break;
      end
      if (obs_we) writes++;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    wrt_smpl = 1'b0;
    trig     = 1'b0;
    trig_pos = '0;

    // Reset values
    @(posedge clk);
    #2;
    checkOutput("rst_waddr", waddr, 0);
    checkOutput("rst_addr_ptr", addr_ptr, 0);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_capture_done", capture_done, 0);
    checkOutput("rst_set_armed", set_armed, 0);
    checkOutput("rst_set_capture_done", set_capture_done, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: trig_pos=100, strobe every 4th clock, 20 ARMED writes before trig
    trig_pos = 9'd100;
    run      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_waddr_start", waddr, 0);
    fillUntilArmed(4, -1, arm_at);
    checkOutput("t1_arm_write", arm_at, 284);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_set_armed_one_cycle", obs_sa, 0);
    checkOutput("t1_armed", armed, 1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t1_waddr_armed", waddr, 304);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_armed_post", armed, 1);
    postUntilDone(4, post_wr, done_seen);
    checkOutput("t1_done_seen", done_seen, 1);
    checkOutput("t1_post_writes", post_wr, 100);
    checkOutput("t1_capture_done", capture_done, 1);
    checkOutput("t1_armed_off", armed, 0);
    checkOutput("t1_waddr_wrapped", waddr, 20);
    checkOutput("t1_addr_ptr", addr_ptr, 20);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_done_no_we", obs_we, 0);
    checkOutput("t1_scd_one_cycle", obs_scd, 0);
    checkOutput("t1_waddr_held", waddr, 20);
    run = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_back_idle", capture_done, 0);

    // 2: trig_pos=0, trig 50 writes after armed, POST is one empty cycle
    trig_pos = 9'd0;
    run      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    fillUntilArmed(1, -1, arm_at);
    checkOutput("t2_arm_write", arm_at, 384);
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_post_no_we", obs_we, 0);
    checkOutput("t2_post_scd", obs_scd, 1);
    checkOutput("t2_capture_done", capture_done, 1);
    checkOutput("t2_addr_ptr", addr_ptr, 50);
    run = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // 3: trig during FILL is ignored, second trig 10 writes after armed
    trig_pos = 9'd10;
    run      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    fillUntilArmed(1, 100, arm_at);
    checkOutput("t3_arm_write", arm_at, 374);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t3_still_armed", armed, 1);
    checkOutput("t3_not_done", capture_done, 0);
    applyStimulus(1'b0, 1'b1);
    postUntilDone(1, post_wr, done_seen);
    checkOutput("t3_done_seen", done_seen, 1);
    checkOutput("t3_post_writes", post_wr, 10);
    checkOutput("t3_addr_ptr", addr_ptr, 10);
    run = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // 4: trig_pos=450 clamps to 383
    trig_pos = 9'd450;
    run      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    fillUntilArmed(1, -1, arm_at);
    checkOutput("t4_arm_write", arm_at, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    postUntilDone(1, post_wr, done_seen);
    checkOutput("t4_done_seen", done_seen, 1);
    checkOutput("t4_post_writes", post_wr, 383);
    checkOutput("t4_addr_ptr", addr_ptr, 5);
    run = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // 5: run dropped mid-POST, then re-run with a new trig_pos
    trig_pos = 9'd20;
    run      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    fillUntilArmed(1, -1, arm_at);
    checkOutput("t5_arm_write", arm_at, 364);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t5_waddr_post", waddr, 369);
    run = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_abort_no_we", obs_we, 0);
    checkOutput("t5_abort_no_scd", obs_scd, 0);
    checkOutput("t5_abort_armed", armed, 0);
    checkOutput("t5_abort_done", capture_done, 0);
    checkOutput("t5_abort_addr_ptr", addr_ptr, 5);
    trig_pos = 9'd383;
    run      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_rerun_waddr", waddr, 0);
    trig_pos = 9'd5;
    fillUntilArmed(1, -1, arm_at);
    checkOutput("t5_relatched_arm_write", arm_at, 1);

    // 6: asynchronous reset while ARMED with strobe held high
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t6_waddr_before", waddr, 4);
    wrt_smpl = 1'b1;
    #1;
    checkOutput("t6_we_before", we, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_we", we, 0);
    checkOutput("t6_rst_armed", armed, 0);
    checkOutput("t6_rst_waddr", waddr, 0);
    run = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("t6_idle_no_we", obs_we, 0);
    end
    checkOutput("t6_idle_waddr", waddr, 0);
    run = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_idle_cycle_no_we", obs_we, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_fill_we", obs_we, 1);
    checkOutput("t6_fill_waddr", waddr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
